// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one pipelined memory port between I-cache fills,
// D-cache fills and D-side write-through stores. Strict D-over-I priority,
// one requester at a time; block fills stream one read address per cycle and
// steer returned words into the granted cache by counting responses.
module mem_fill_arbiter #(
  parameter int BLK_WORDS = 8,
  parameter int ADDR_W    = 16,
  localparam int WW       = $clog2(BLK_WORDS),
  localparam int CW       = WW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [15:0]       d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       fill_data,
  output logic [WW-1:0]     fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_done,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL} state_t;

  // Byte offset bits covered by one block (block = 2*BLK_WORDS bytes).
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * BLK_WORDS - 1);

  state_t            r_state;
  logic              r_owner;      // 0 = I-cache, 1 = D-cache
  logic [CW-1:0]     r_issue_cnt;  // reads issued in this fill
  logic [CW-1:0]     r_recv_cnt;   // responses accepted in this fill
  logic [ADDR_W-1:0] r_base;       // block base (FILL) or store address (WRITE)
  logic [15:0]       r_wdata;

  logic              w_issue;
  logic              w_acc;
  logic              w_last;
  logic [ADDR_W-1:0] w_off;

  // MSB of a counter set means all BLK_WORDS have been issued / received,
  // so late or stale responses are never steered into a cache.
  assign w_issue = (r_state == S_FILL) && !r_issue_cnt[CW-1];
  assign w_acc   = (r_state == S_FILL) && mem_rvalid && !r_recv_cnt[CW-1];
  assign w_last  = w_acc && (r_recv_cnt == CW'(BLK_WORDS - 1));
  assign w_off   = ADDR_W'({r_issue_cnt[WW-1:0], 1'b0});

  // Memory side: strobes decode from registered state only.
  assign mem_en    = w_issue || (r_state == S_WRITE);
  assign mem_wr    = (r_state == S_WRITE);
  assign mem_addr  = (r_state == S_WRITE) ? r_base :
                     w_issue              ? r_base + w_off : '0;
  assign mem_wdata = (r_state == S_WRITE) ? r_wdata : '0;

  // Cache side: responses are steered in the cycle they arrive.
  assign fill_data   = w_acc ? mem_rdata : '0;
  assign fill_word   = w_acc ? r_recv_cnt[WW-1:0] : '0;
  assign i_fill_we   = w_acc  && !r_owner;
  assign d_fill_we   = w_acc  &&  r_owner;
  assign i_fill_done = w_last && !r_owner;
  assign d_fill_done = w_last &&  r_owner;
  assign d_wr_done   = (r_state == S_WRITE);
  assign busy        = (r_state != S_IDLE);

  // Grant / sequencing FSM with issue and receive counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_issue_cnt <= '0;
          r_recv_cnt  <= '0;
          if (d_wr) begin
            r_base  <= d_addr;
            r_wdata <= d_wdata;
            r_state <= S_WRITE;
          end else if (d_miss) begin
            r_base  <= d_addr & ~BLK_MASK;
            r_owner <= 1'b1;
            r_state <= S_FILL;
          end else if (i_miss) begin
            r_base  <= i_addr & ~BLK_MASK;
            r_owner <= 1'b0;
            r_state <= S_FILL;
          end
        end
        S_WRITE: r_state <= S_IDLE;
        S_FILL: begin
          if (w_issue) r_issue_cnt <= r_issue_cnt + CW'(1);
          if (w_acc)   r_recv_cnt  <= r_recv_cnt + CW'(1);
          if (w_last)  r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: directed bench for mem_fill_arbiter with an in-order
// pipelined memory model (fixed latency, optional random response gaps).
module tb_mem_fill_arbiter;
  localparam int BW  = 8;
  localparam int AW  = 16;
  localparam int LAT = 4;
  localparam logic [15:0] KEY = 16'h5A5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_miss, d_miss, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [15:0]   d_wdata;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, mem_rdata;
  logic          mem_rvalid;
  logic [15:0]   fill_data;
  logic [2:0]    fill_word;
  logic          i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy;

  mem_fill_arbiter #(.BLK_WORDS(BW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr),
    .d_wr(d_wr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_done(d_wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit gap_mode = 1'b0;

  // memory model request queue
  logic [15:0] q_a[$];
  int          q_t[$];
  int          rv_cnt;

  // observation logs
  logic [15:0] ia[$];
  int          ic[$];
  logic [15:0] wa[$], wd[$];
  logic        wdone[$];
  int          wc;
  logic [2:0]  fw[$];
  logic [15:0] fd[$];
  logic        fown[$], fdone[$];
  int          n_idone, n_ddone, d_done_cyc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    ia.delete(); ic.delete(); wa.delete(); wd.delete(); wdone.delete();
    fw.delete(); fd.delete(); fown.delete(); fdone.delete();
    n_idone = 0; n_ddone = 0; d_done_cyc = 0; wc = 0; rv_cnt = 0;
  endtask

  // Memory model: in-order responses, at least LAT cycles after issue.
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    if (q_a.size() > 0 && (cyc - q_t[0]) >= LAT &&
        (!gap_mode || $urandom_range(0, 2) != 0)) begin
      mem_rvalid = 1'b1;
      mem_rdata  = q_a[0] ^ KEY;
      rv_cnt++;
      void'(q_a.pop_front());
      void'(q_t.pop_front());
    end
    if (mem_en && !mem_wr) begin
      q_a.push_back(mem_addr);
      q_t.push_back(cyc);
    end
  end

  // Monitor: log every memory access, fill write and done pulse.
  always @(posedge clk) begin
    #3;
    if (mem_en && !mem_wr) begin ia.push_back(mem_addr); ic.push_back(cyc); end
    if (mem_en && mem_wr) begin
      wa.push_back(mem_addr); wd.push_back(mem_wdata); wdone.push_back(d_wr_done); wc = cyc;
    end
    if (i_fill_we || d_fill_we) begin
      fw.push_back(fill_word); fd.push_back(fill_data);
      fown.push_back(d_fill_we); fdone.push_back(i_fill_done | d_fill_done);
    end
    if (i_fill_done) n_idone++;
    if (d_fill_done) begin n_ddone++; d_done_cyc = cyc; end
  end

  // which: 0 = i_fill_done, 1 = d_fill_done, 2 = d_wr_done
  task automatic wait_ev(input int which, input int maxc, output int busy_lo);
    busy_lo = 0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (!busy) busy_lo++;
      if ((which == 0 && i_fill_done) || (which == 1 && d_fill_done) ||
          (which == 2 && d_wr_done)) return;
    end
    chk($sformatf("timeout_ev%0d", which), 0, 1);
  endtask

  task automatic check_fill(input string t, input int fo, input int io, input int tot,
                            input logic [15:0] base, input logic own);
    chk({t, "_nfill"}, fw.size(), tot);
    chk({t, "_niss"}, ia.size(), tot);
    for (int k = 0; k < BW; k++) begin
      if (fo + k < fw.size()) begin
        chk($sformatf("%s_word%0d", t, k), fw[fo+k], k);
        chk($sformatf("%s_data%0d", t, k), fd[fo+k], (base + 16'(2*k)) ^ KEY);
        chk($sformatf("%s_own%0d", t, k), fown[fo+k], own);
        chk($sformatf("%s_done%0d", t, k), fdone[fo+k], (k == BW-1));
      end
      if (io + k < ia.size()) begin
        chk($sformatf("%s_addr%0d", t, k), ia[io+k], base + 16'(2*k));
        chk($sformatf("%s_icyc%0d", t, k), ic[io+k] - ic[io], k);
      end
    end
  endtask

  int bl;

  initial begin
    rst = 1'b1; i_miss = 0; d_miss = 1; d_wr = 0;
    i_addr = '0; d_addr = 16'h0A16; d_wdata = '0;
    mem_rvalid = 0; mem_rdata = '0;
    clear_logs();

    // 1: reset with a pending D miss
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_outs", {mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we,
                     d_fill_we, i_fill_done, d_fill_done, d_wr_done}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("grant_after_rst", busy, 1);
    wait_ev(1, 40, bl);
    d_miss = 0;
    check_fill("t1", 0, 0, 8, 16'h0A10, 1'b1);

    // 2: I miss at 0x1234
    @(negedge clk); clear_logs();
    i_addr = 16'h1234; i_miss = 1;
    wait_ev(0, 40, bl);
    i_miss = 0;
    check_fill("t2", 0, 0, 8, 16'h1230, 1'b0);
    chk("t2_ndone_i", n_idone, 1);
    chk("t2_ndone_d", n_ddone, 0);

    // 3: simultaneous I and D miss, D first
    @(negedge clk); clear_logs();
    i_addr = 16'h0040; i_miss = 1; d_addr = 16'h8006; d_miss = 1;
    wait_ev(1, 40, bl);
    d_miss = 0;
    wait_ev(0, 40, bl);
    i_miss = 0;
    check_fill("t3d", 0, 0, 16, 16'h8000, 1'b1);
    check_fill("t3i", 8, 8, 16, 16'h0040, 1'b0);
    chk("t3_gap", (ic.size() > 8) && (ic[8] - d_done_cyc >= 2), 1);

    // 4: store and D miss together, store first
    @(negedge clk); clear_logs();
    d_addr = 16'h2002; d_wdata = 16'hBEEF; d_wr = 1; d_miss = 1;
    wait_ev(2, 10, bl);
    d_wr = 0; d_addr = 16'h3000;
    wait_ev(1, 40, bl);
    d_miss = 0;
    chk("t4_nwr", wa.size(), 1);
    chk("t4_waddr", wa.size() > 0 ? wa[0] : 16'h0, 16'h2002);
    chk("t4_wdata", wd.size() > 0 ? wd[0] : 16'h0, 16'hBEEF);
    chk("t4_wdone", wdone.size() > 0 ? wdone[0] : 1'b0, 1);
    chk("t4_gap", (ic.size() > 0) && (ic[0] - wc >= 2), 1);
    check_fill("t4", 0, 0, 8, 16'h3000, 1'b1);

    // 5: reset after the 3rd fill write of a D fill
    @(negedge clk); clear_logs();
    d_addr = 16'h4008; d_miss = 1;
    for (int k = 0; k < 40 && fw.size() < 3; k++) @(negedge clk);
    rst = 1; d_miss = 0;
    chk("t5_nfill_pre", fw.size(), 3);
    @(negedge clk); clear_logs();
    rst = 0;
    repeat (8) @(negedge clk);
    chk("t5_nfill_post", fw.size(), 0);
    chk("t5_ndone", n_ddone + n_idone, 0);
    chk("t5_niss", ia.size(), 0);
    chk("t5_busy", busy, 0);
    chk("t5_stale_rv", rv_cnt > 0, 1);
    clear_logs();
    i_addr = 16'h0100; i_miss = 1;
    wait_ev(0, 40, bl);
    i_miss = 0;
    check_fill("t5i", 0, 0, 8, 16'h0100, 1'b0);

    // 6: random response gaps
    @(negedge clk); clear_logs();
    gap_mode = 1;
    d_addr = 16'h5A5E; d_miss = 1;
    wait_ev(1, 200, bl);
    d_miss = 0; gap_mode = 0;
    check_fill("t6", 0, 0, 8, 16'h5A50, 1'b1);
    chk("t6_busy", bl, 0);
    chk("t6_ndone", n_ddone, 1);

    // 7: top-of-memory block, no wrap inside the block
    @(negedge clk); clear_logs();
    i_addr = 16'hFFF7; i_miss = 1;
    wait_ev(0, 40, bl);
    i_miss = 0;
    check_fill("t7", 0, 0, 8, 16'hFFF0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
